// File: rtl/pc_unit_pkg.sv
// Shared core package: RV32I decoded-instruction enum, PC FSM states, PC step size.
package pc_unit_pkg;

   localparam int unsigned PC_INSTR_BYTES = 4;

   typedef enum logic [5:0] {
      INSTR_LUI,  INSTR_AUIPC, INSTR_JAL,  INSTR_JALR,
      INSTR_BEQ,  INSTR_BNE,   INSTR_BLT,  INSTR_BGE,  INSTR_BLTU, INSTR_BGEU,
      INSTR_LB,   INSTR_LH,    INSTR_LW,   INSTR_LBU,  INSTR_LHU,
      INSTR_SB,   INSTR_SH,    INSTR_SW,
      INSTR_ADDI, INSTR_SLTI,  INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
      INSTR_SLLI, INSTR_SRLI,  INSTR_SRAI,
      INSTR_ADD,  INSTR_SUB,   INSTR_SLL,  INSTR_SLT,  INSTR_SLTU,
      INSTR_XOR,  INSTR_SRL,   INSTR_SRA,  INSTR_OR,   INSTR_AND,
      INSTR_FENCE, INSTR_ECALL, INSTR_EBREAK
   } rv32i_base_instr;

   typedef enum logic {
      S_BOOT = 1'b0,
      S_RUN  = 1'b1
   } pc_state_e;

   // True for the six conditional-branch opcodes.
   function automatic logic is_cond_branch(input rv32i_base_instr op);
      return (op == INSTR_BEQ)  || (op == INSTR_BNE)  ||
             (op == INSTR_BLT)  || (op == INSTR_BGE)  ||
             (op == INSTR_BLTU) || (op == INSTR_BGEU);
   endfunction

endpackage

// File: rtl/pc_target.sv
// Combinational branch/jump resolution: taken decision, redirect target, misalign flag.
module pc_target
   import pc_unit_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  ex_valid,
   input  logic [ADDR_WIDTH-1:0] ex_pc,
   input  rv32i_base_instr       opcode,
   input  logic [DATA_WIDTH-1:0] imm_value,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_eq,
   input  logic                  alu_lt,
   input  logic                  alu_ltu,
   output logic                  taken_c,
   output logic [ADDR_WIDTH-1:0] target_c,
   output logic                  misalign_c
);

   logic                  cond_hit;
   logic                  is_jump;
   logic                  is_jalr;
   logic [ADDR_WIDTH-1:0] imm_addr;
   logic [ADDR_WIDTH-1:0] alu_addr;

   assign imm_addr = ADDR_WIDTH'(imm_value);
   assign alu_addr = ADDR_WIDTH'(alu_result);

   // Decode the opcode into a branch condition outcome or an unconditional jump.
   always_comb begin
      cond_hit = 1'b0;
      is_jump  = 1'b0;
      is_jalr  = 1'b0;
      case (opcode)
         INSTR_BEQ:  cond_hit = alu_eq;
         INSTR_BNE:  cond_hit = !alu_eq;
         INSTR_BLT:  cond_hit = alu_lt;
         INSTR_BGE:  cond_hit = !alu_lt;
         INSTR_BLTU: cond_hit = alu_ltu;
         INSTR_BGEU: cond_hit = !alu_ltu;
         INSTR_JAL:  is_jump  = 1'b1;
         INSTR_JALR: begin
            is_jump = 1'b1;
            is_jalr = 1'b1;
         end
         default: ;
      endcase
   end

   // JALR clears bit 0; JAL and branches are PC-relative.
   always_comb begin
      taken_c    = ex_valid && (cond_hit || is_jump);
      target_c   = is_jalr ? {alu_addr[ADDR_WIDTH-1:1], 1'b0} : (ex_pc + imm_addr);
      misalign_c = taken_c && target_c[1];
   end

endmodule

// File: rtl/pc_unit.sv
// Registered program-counter unit: owns the PC, issues fetch requests over valid/ready,
// applies branch/jump redirects from execute and traps on misaligned targets.
// Optional build macro PC_PERF_CNT_EN adds taken-branch and redirect counters.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH   = 32,
   parameter int unsigned            DATA_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   output logic                  if_valid_o,
   input  logic                  if_ready_i,
   output logic [ADDR_WIDTH-1:0] if_pc_o,
   input  logic                  ex_valid_i,
   input  logic [ADDR_WIDTH-1:0] ex_pc_i,
   input  rv32i_base_instr       opcode_i,
   input  logic [DATA_WIDTH-1:0] imm_value_i,
   input  logic [DATA_WIDTH-1:0] alu_result_i,
   input  logic                  alu_eq_i,
   input  logic                  alu_lt_i,
   input  logic                  alu_ltu_i,
   input  logic [ADDR_WIDTH-1:0] trap_vec_i,
   output logic [ADDR_WIDTH-1:0] link_addr_o,
`ifdef PC_PERF_CNT_EN
   output logic [31:0]           taken_cnt_o,
   output logic [31:0]           redirect_cnt_o,
`endif
   output logic                  redirect_o,
   output logic                  exc_misalign_o,
   output logic [ADDR_WIDTH-1:0] exc_addr_o
);

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(PC_INSTR_BYTES);

   pc_state_e             state_q;
   pc_state_e             state_d;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_d;
   logic                  taken_c;
   logic                  misalign_c;
   logic [ADDR_WIDTH-1:0] target_c;
   logic                  handshake_c;

   pc_target #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_pc_target (
      .ex_valid   (ex_valid_i),
      .ex_pc      (ex_pc_i),
      .opcode     (opcode_i),
      .imm_value  (imm_value_i),
      .alu_result (alu_result_i),
      .alu_eq     (alu_eq_i),
      .alu_lt     (alu_lt_i),
      .alu_ltu    (alu_ltu_i),
      .taken_c    (taken_c),
      .target_c   (target_c),
      .misalign_c (misalign_c)
   );

   assign if_pc_o     = pc_q;
   assign link_addr_o = ex_pc_i + PC_STEP;
   assign handshake_c = if_valid_o && if_ready_i;

   // Boot lasts exactly one cycle, then the unit runs forever.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_BOOT:  state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         default: state_d = S_BOOT;
      endcase
   end

   // Next PC: trap beats redirect beats sequential advance.
   always_comb begin
      pc_d = pc_q;
      if (misalign_c) begin
         pc_d = {trap_vec_i[ADDR_WIDTH-1:2], 2'b00};
      end else if (taken_c) begin
         pc_d = target_c;
      end else if (handshake_c) begin
         pc_d = pc_q + PC_STEP;
      end
   end

   // State, PC and registered fetch/redirect/exception outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= S_BOOT;
         pc_q           <= RESET_VECTOR;
         if_valid_o     <= 1'b0;
         redirect_o     <= 1'b0;
         exc_misalign_o <= 1'b0;
         exc_addr_o     <= '0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         if_valid_o     <= (state_d == S_RUN);
         redirect_o     <= taken_c;
         exc_misalign_o <= misalign_c;
         if (misalign_c) begin
            exc_addr_o <= target_c;
         end
      end
   end

`ifdef PC_PERF_CNT_EN
   // Free-running wrap-around event counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         taken_cnt_o    <= '0;
         redirect_cnt_o <= '0;
      end else begin
         if (taken_c && is_cond_branch(opcode_i)) begin
            taken_cnt_o <= taken_cnt_o + 32'd1;
         end
         if (taken_c) begin
            redirect_cnt_o <= redirect_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (RESET_VECTOR = 'h100).
module tb_pc_unit;
   import pc_unit_pkg::*;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            if_valid_o;
   logic            if_ready_i;
   logic [31:0]     if_pc_o;
   logic            ex_valid_i;
   logic [31:0]     ex_pc_i;
   rv32i_base_instr opcode_i;
   logic [31:0]     imm_value_i;
   logic [31:0]     alu_result_i;
   logic            alu_eq_i;
   logic            alu_lt_i;
   logic            alu_ltu_i;
   logic [31:0]     trap_vec_i;
   logic [31:0]     link_addr_o;
   logic            redirect_o;
   logic            exc_misalign_o;
   logic [31:0]     exc_addr_o;
`ifdef PC_PERF_CNT_EN
   logic [31:0]     taken_cnt_o;
   logic [31:0]     redirect_cnt_o;
`endif

   int unsigned pass_cnt = 0;
   int unsigned chk_cnt  = 0;

   pc_unit #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .RESET_VECTOR (32'h100)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .if_valid_o     (if_valid_o),
      .if_ready_i     (if_ready_i),
      .if_pc_o        (if_pc_o),
      .ex_valid_i     (ex_valid_i),
      .ex_pc_i        (ex_pc_i),
      .opcode_i       (opcode_i),
      .imm_value_i    (imm_value_i),
      .alu_result_i   (alu_result_i),
      .alu_eq_i       (alu_eq_i),
      .alu_lt_i       (alu_lt_i),
      .alu_ltu_i      (alu_ltu_i),
      .trap_vec_i     (trap_vec_i),
      .link_addr_o    (link_addr_o),
`ifdef PC_PERF_CNT_EN
      .taken_cnt_o    (taken_cnt_o),
      .redirect_cnt_o (redirect_cnt_o),
`endif
      .redirect_o     (redirect_o),
      .exc_misalign_o (exc_misalign_o),
      .exc_addr_o     (exc_addr_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic resolve(input rv32i_base_instr op, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] alu);
      ex_valid_i   = 1'b1;
      opcode_i     = op;
      ex_pc_i      = pc;
      imm_value_i  = imm;
      alu_result_i = alu;
   endtask

   initial begin
      rst_ni       = 1'b0;
      if_ready_i   = 1'b0;
      ex_valid_i   = 1'b0;
      ex_pc_i      = '0;
      opcode_i     = INSTR_ADDI;
      imm_value_i  = '0;
      alu_result_i = '0;
      alu_eq_i     = 1'b0;
      alu_lt_i     = 1'b0;
      alu_ltu_i    = 1'b0;
      trap_vec_i   = 32'h800;
      #12;
      check("rst_valid",    32'(if_valid_o),     32'd0);
      check("rst_pc",       if_pc_o,             32'h100);
      check("rst_redirect", 32'(redirect_o),     32'd0);
      check("rst_exc",      32'(exc_misalign_o), 32'd0);
      check("rst_exc_addr", exc_addr_o,          32'h0);

      // Reset release and sequential fetch.
      if_ready_i = 1'b1;
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check("boot_valid", 32'(if_valid_o), 32'd0);
      tick();
      check("run_valid", 32'(if_valid_o), 32'd1);
      check("run_pc0",   if_pc_o,         32'h100);
      tick();
      check("run_pc1",   if_pc_o,         32'h104);
      tick();
      check("run_pc2",   if_pc_o,         32'h108);

      // JAL to 'h200, then stall for three cycles.
      resolve(INSTR_JAL, 32'h108, 32'hF8, 32'h0);
      #1;
      check("link_addr", link_addr_o, 32'h10C);
      tick();
      check("jal_pc",  if_pc_o,         32'h200);
      check("jal_red", 32'(redirect_o), 32'd1);
      ex_valid_i = 1'b0;
      if_ready_i = 1'b0;
      tick();
      check("stall_pc0",  if_pc_o,         32'h200);
      check("stall_red",  32'(redirect_o), 32'd0);
      check("stall_valid", 32'(if_valid_o), 32'd1);
      tick();
      check("stall_pc1", if_pc_o, 32'h200);
      tick();
      check("stall_pc2", if_pc_o, 32'h200);
      if_ready_i = 1'b1;
      tick();
      check("unstall_pc", if_pc_o, 32'h204);

      // BEQ taken with concurrent handshake, then not taken.
      resolve(INSTR_BEQ, 32'h40, 32'h20, 32'h0);
      alu_eq_i = 1'b1;
      tick();
      check("beq_t_pc",  if_pc_o,         32'h60);
      check("beq_t_red", 32'(redirect_o), 32'd1);
      ex_valid_i = 1'b0;
      alu_eq_i   = 1'b0;
      tick();
      check("beq_pulse_pc",  if_pc_o,         32'h64);
      check("beq_pulse_red", 32'(redirect_o), 32'd0);
      resolve(INSTR_BEQ, 32'h40, 32'h20, 32'h0);
      tick();
      check("beq_nt_pc",  if_pc_o,         32'h68);
      check("beq_nt_red", 32'(redirect_o), 32'd0);

      // BGE taken with negative offset; BLTU not taken; ALU op never redirects.
      resolve(INSTR_BGE, 32'h300, 32'hFFFF_FF00, 32'h0);
      alu_lt_i = 1'b0;
      tick();
      check("bge_pc",  if_pc_o,         32'h200);
      check("bge_red", 32'(redirect_o), 32'd1);
      resolve(INSTR_BLTU, 32'h300, 32'h10, 32'h0);
      alu_ltu_i = 1'b0;
      tick();
      check("bltu_pc",  if_pc_o,         32'h204);
      check("bltu_red", 32'(redirect_o), 32'd0);
      resolve(INSTR_ADDI, 32'h300, 32'h10, 32'h0);
      tick();
      check("addi_pc",  if_pc_o,         32'h208);
      check("addi_red", 32'(redirect_o), 32'd0);

      // JALR: bit 0 cleared, then misaligned target traps.
      resolve(INSTR_JALR, 32'h0, 32'h0, 32'h1001);
      tick();
      check("jalr_pc",  if_pc_o,             32'h1000);
      check("jalr_red", 32'(redirect_o),     32'd1);
      check("jalr_exc", 32'(exc_misalign_o), 32'd0);
      resolve(INSTR_JALR, 32'h0, 32'h0, 32'h1002);
      trap_vec_i = 32'h803;
      tick();
      check("trap_pc",   if_pc_o,             32'h800);
      check("trap_exc",  32'(exc_misalign_o), 32'd1);
      check("trap_addr", exc_addr_o,          32'h1002);
      check("trap_red",  32'(redirect_o),     32'd1);
      ex_valid_i = 1'b0;
      tick();
      check("post_trap_pc",   if_pc_o,             32'h804);
      check("post_trap_exc",  32'(exc_misalign_o), 32'd0);
      check("post_trap_addr", exc_addr_o,          32'h1002);

      // Misaligned taken BNE also traps.
      resolve(INSTR_BNE, 32'h10, 32'h2, 32'h0);
      alu_eq_i = 1'b0;
      tick();
      check("bne_trap_pc",   if_pc_o,             32'h800);
      check("bne_trap_exc",  32'(exc_misalign_o), 32'd1);
      check("bne_trap_addr", exc_addr_o,          32'h12);
      ex_valid_i = 1'b0;
      tick();
      check("bne_post_pc", if_pc_o, 32'h804);

      // PC wrap at top of address space.
      resolve(INSTR_JAL, 32'h0, 32'hFFFF_FFFC, 32'h0);
      tick();
      check("wrap_top", if_pc_o, 32'hFFFF_FFFC);
      ex_valid_i = 1'b0;
      tick();
      check("wrap_zero", if_pc_o, 32'h0);

      // Reset asserted while a redirect is in flight.
      resolve(INSTR_JAL, 32'h0, 32'h500, 32'h0);
      tick();
      check("pre_rst_pc",  if_pc_o,         32'h500);
      check("pre_rst_red", 32'(redirect_o), 32'd1);
`ifdef PC_PERF_CNT_EN
      check("cnt_taken",    taken_cnt_o,    32'd3);
      check("cnt_redirect", redirect_cnt_o, 32'd8);
`endif
      rst_ni = 1'b0;
      #1;
      check("mid_rst_pc",    if_pc_o,             32'h100);
      check("mid_rst_red",   32'(redirect_o),     32'd0);
      check("mid_rst_valid", 32'(if_valid_o),     32'd0);
      check("mid_rst_exc",   32'(exc_misalign_o), 32'd0);
      check("mid_rst_addr",  exc_addr_o,          32'h0);
`ifdef PC_PERF_CNT_EN
      check("rst_cnt_taken",    taken_cnt_o,    32'd0);
      check("rst_cnt_redirect", redirect_cnt_o, 32'd0);
`endif

      // Resolution during boot is applied.
      @(negedge clk_i);
      resolve(INSTR_JAL, 32'h0, 32'h700, 32'h0);
      rst_ni = 1'b1;
      tick();
      check("boot_jal_pc",    if_pc_o,         32'h700);
      check("boot_jal_red",   32'(redirect_o), 32'd1);
      check("boot_jal_valid", 32'(if_valid_o), 32'd1);
`ifdef PC_PERF_CNT_EN
      check("boot_cnt_taken",    taken_cnt_o,    32'd0);
      check("boot_cnt_redirect", redirect_cnt_o, 32'd1);
`endif
      ex_valid_i = 1'b0;
      tick();
      check("boot_post_pc",  if_pc_o,         32'h704);
      check("boot_post_red", 32'(redirect_o), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
